muldiv_seq: RTL



---
 rtl/muldiv_seq.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer beside the EX-stage ALU.
// Executes mult/multu/div/divu in WIDTH+1 cycles (WIDTH iteration steps plus
// one sign-fix cycle), holds the HI/LO registers, accepts mthi/mtlo writes and
// stalls the pipeline while an operation is in flight.
// Optional build macro: MULDIV_DIV0_FLAG_EN (registered divide-by-zero flag).
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  // Shared datapath: multiply uses acc = running upper product, low = multiplier
  // shifting out / product low half shifting in, opnd = multiplicand.
  // Divide uses acc = partial remainder, low = dividend / quotient, opnd = divisor.
  logic [WIDTH-1:0] acc, low, opnd;
  logic             is_div, neg_lo, neg_hi, b_zero;

  logic             accept, last_step, signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // A start in the done cycle is the retiring instruction, so it is ignored.
  assign accept    = (state == IDLE) & start & ~flush & ~done;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // Signed ops run on magnitudes; the signs are reapplied in FIX.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One shift-add multiply step and one restoring-divide step.
  assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc, low[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};

  // Sign correction. A zero divisor leaves rem = |a|, so the remainder fix
  // restores the original dividend; the quotient is forced to all ones.
  assign prod      = {acc, low};
  assign prod_fix  = neg_lo ? -prod : prod;
  assign quo_fix   = b_zero ? {WIDTH{1'b1}} : (neg_lo ? -low : low);
  assign rem_fix   = neg_hi ? -acc : acc;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic and pipeline handshake outputs.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    stall      = (state != IDLE) | (start & (state == IDLE) & ~done);
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        if (flush)          state_next = IDLE;
        else if (last_step) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath, iteration counter and HI/LO architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      low    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      b_zero <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      // mthi/mtlo land in any state but FIX, where the result owns HI/LO.
      if (state != FIX) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            is_div <= op[1];
            low    <= op[1] ? a_mag : b_mag;
            opnd   <= op[1] ? b_mag : a_mag;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            b_zero <= (b == '0);
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) begin
              acc <= div_diff[WIDTH-1:0];
              low <= {low[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_shift[WIDTH-1:0];
              low <= {low[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= mul_sum[WIDTH:1];
            low <= {mul_sum[0], low[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  // Sticky divide-by-zero flag: set with done, cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div0 <= 1'b0;
    else if (accept)
      div0 <= 1'b0;
    else if ((state == FIX) && !flush && is_div && b_zero)
      div0 <= 1'b1;
  end
`else
  assign div0 = 1'b0;
`endif

endmodule
